// File: rtl/npu_pkg.sv
// Shared definitions for the NPU AXI4-Lite register slave: widths, register
// offsets, CTRL/STATUS bit positions, response codes and the address decoder.
package npu_pkg;

  localparam int unsigned AXI_ADDR_WIDTH = 32;
  localparam int unsigned AXI_DATA_WIDTH = 32;
  localparam int unsigned DATA_WIDTH     = 16;
  localparam int unsigned MATRIX_SIZE    = 8;
  localparam int unsigned WEIGHT_COUNT   = MATRIX_SIZE * MATRIX_SIZE;
  localparam int unsigned MEM_ADDR_WIDTH = 7;
  localparam int unsigned RES_IDX_WIDTH  = 3;
  localparam int unsigned CFG_WIDTH      = 16;
  localparam int unsigned DEC_WIDTH      = 12;

  // Region base offsets inside the decoded 4 KiB window
  localparam logic [DEC_WIDTH-1:0] OFS_CTRL   = 12'h000;
  localparam logic [DEC_WIDTH-1:0] OFS_STATUS = 12'h004;
  localparam logic [DEC_WIDTH-1:0] OFS_CONFIG = 12'h008;
  localparam logic [DEC_WIDTH-1:0] OFS_WEIGHT = 12'h100;
  localparam logic [DEC_WIDTH-1:0] OFS_INPUT  = 12'h200;
  localparam logic [DEC_WIDTH-1:0] OFS_RESULT = 12'h300;

  localparam int unsigned CTRL_SOFT_RST_BIT = 0;
  localparam int unsigned CTRL_START_BIT    = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT   = 2;
  localparam int unsigned STATUS_BUSY_BIT   = 0;
  localparam int unsigned STATUS_DONE_BIT   = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [CFG_WIDTH-1:0] CONFIG_RESET = 16'h0008;

  typedef enum logic [2:0] {
    REGION_NONE,
    REGION_CTRL,
    REGION_STATUS,
    REGION_CONFIG,
    REGION_WEIGHT,
    REGION_INPUT,
    REGION_RESULT
  } region_e;

  // Map a decoded byte address onto its register region
  function automatic region_e decode_addr(input logic [DEC_WIDTH-1:0] addr);
    region_e r;
    r = REGION_NONE;
    if (addr[11:2] == OFS_CTRL[11:2])
      r = REGION_CTRL;
    else if (addr[11:2] == OFS_STATUS[11:2])
      r = REGION_STATUS;
    else if (addr[11:2] == OFS_CONFIG[11:2])
      r = REGION_CONFIG;
    else if (addr[11:8] == OFS_WEIGHT[11:8])
      r = REGION_WEIGHT;
    else if (addr[11:5] == OFS_INPUT[11:5])
      r = REGION_INPUT;
    else if (addr[11:5] == OFS_RESULT[11:5])
      r = REGION_RESULT;
    return r;
  endfunction

endpackage

// File: rtl/npu_axil_slave_if.sv
// AXI4-Lite bus between a host master and the NPU register slave.
// Signals: AW (awaddr/awvalid/awready), W (wdata/wvalid/wready),
// B (bresp/bvalid/bready), AR (araddr/arvalid/arready),
// R (rdata/rresp/rvalid/rready).
interface npu_axil_slave_if;
  import npu_pkg::*;

  logic [AXI_ADDR_WIDTH-1:0] awaddr;
  logic                      awvalid;
  logic                      awready;
  logic [AXI_DATA_WIDTH-1:0] wdata;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [AXI_ADDR_WIDTH-1:0] araddr;
  logic                      arvalid;
  logic                      arready;
  logic [AXI_DATA_WIDTH-1:0] rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/npu_axil_slave.sv
// AXI4-Lite register slave for the NPU core: control/status/config registers,
// operand (weight/input) write strobes towards the core memory and a result
// buffer filled by the core.
// Ports:
//   aclk, areset            clock, synchronous active-high reset
//   s_axi                   AXI4-Lite slave port
//   soft_rst, start, cfg    core control (level, one-cycle pulse, config word)
//   mem_we/mem_addr/mem_data operand write strobe, index and value
//   busy, done              core status inputs
//   res_we/res_idx/res_data result write from the core
//   interrupt               done_sticky gated by irq_en
module npu_axil_slave
  import npu_pkg::*;
(
  input  logic                      aclk,
  input  logic                      areset,
  npu_axil_slave_if.slave           s_axi,
  output logic                      soft_rst,
  output logic                      start,
  output logic [CFG_WIDTH-1:0]      cfg,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_data,
  input  logic                      busy,
  input  logic                      done,
  input  logic                      res_we,
  input  logic [RES_IDX_WIDTH-1:0]  res_idx,
  input  logic [DATA_WIDTH-1:0]     res_data,
  output logic                      interrupt
);

  // Captured write channels
  logic                  aw_full;
  logic                  w_full;
  logic [DEC_WIDTH-1:0]  aw_addr;
  logic [DATA_WIDTH-1:0] w_data;

  logic                  irq_en;
  logic                  done_sticky;
  logic [DATA_WIDTH-1:0] result [MATRIX_SIZE];

  // Handshake and next-state terms
  logic                      aw_hs_c, w_hs_c, b_hs_c, ar_hs_c, r_hs_c;
  logic                      wr_go_c;
  logic                      aw_full_n_c, w_full_n_c, bvalid_n_c, rvalid_n_c;
  region_e                   wr_region_c, rd_region_c;
  logic [1:0]                wr_resp_c;
  logic                      ctrl_wr_c, cfg_wr_c, mem_wr_c, start_go_c;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_c;
  logic [AXI_DATA_WIDTH-1:0] rd_data_c;
  logic [1:0]                rd_resp_c;
  logic [DATA_WIDTH-1:0]     rd_res_c;

  logic unused_c;
  assign unused_c = ^{s_axi.awaddr[AXI_ADDR_WIDTH-1:DEC_WIDTH],
                      s_axi.araddr[AXI_ADDR_WIDTH-1:DEC_WIDTH],
                      s_axi.wdata[AXI_DATA_WIDTH-1:DATA_WIDTH]};

  // Channel handshakes and holding-register occupancy
  always_comb begin
    aw_hs_c = s_axi.awvalid & s_axi.awready;
    w_hs_c  = s_axi.wvalid & s_axi.wready;
    b_hs_c  = s_axi.bvalid & s_axi.bready;
    ar_hs_c = s_axi.arvalid & s_axi.arready;
    r_hs_c  = s_axi.rvalid & s_axi.rready;
    wr_go_c = aw_full & w_full & ~s_axi.bvalid;

    aw_full_n_c = aw_full;
    w_full_n_c  = w_full;
    bvalid_n_c  = s_axi.bvalid;
    rvalid_n_c  = s_axi.rvalid;
    if (aw_hs_c) aw_full_n_c = 1'b1;
    if (w_hs_c)  w_full_n_c  = 1'b1;
    if (wr_go_c) bvalid_n_c  = 1'b1;
    // Both holding registers are released together on the B handshake
    if (b_hs_c) begin
      aw_full_n_c = 1'b0;
      w_full_n_c  = 1'b0;
      bvalid_n_c  = 1'b0;
    end
    if (ar_hs_c)
      rvalid_n_c = 1'b1;
    else if (r_hs_c)
      rvalid_n_c = 1'b0;
  end

  // Write decode: response and side-effect strobes for the held transaction
  always_comb begin
    wr_region_c = decode_addr(aw_addr);
    wr_resp_c   = RESP_OKAY;
    ctrl_wr_c   = 1'b0;
    cfg_wr_c    = 1'b0;
    mem_wr_c    = 1'b0;
    start_go_c  = 1'b0;
    mem_addr_c  = '0;
    if (wr_go_c) begin
      case (wr_region_c)
        REGION_CTRL: begin
          ctrl_wr_c  = 1'b1;
          // Start is ignored while busy or when soft reset is requested too
          start_go_c = w_data[CTRL_START_BIT] & ~busy & ~w_data[CTRL_SOFT_RST_BIT];
        end
        REGION_CONFIG: cfg_wr_c = 1'b1;
        REGION_WEIGHT: begin
          if (busy) begin
            wr_resp_c = RESP_SLVERR;
          end else begin
            mem_wr_c   = 1'b1;
            mem_addr_c = MEM_ADDR_WIDTH'({1'b0, aw_addr[7:2]});
          end
        end
        REGION_INPUT: begin
          if (busy) begin
            wr_resp_c = RESP_SLVERR;
          end else begin
            mem_wr_c   = 1'b1;
            mem_addr_c = MEM_ADDR_WIDTH'(WEIGHT_COUNT) + MEM_ADDR_WIDTH'(aw_addr[4:2]);
          end
        end
        default: wr_resp_c = RESP_SLVERR;
      endcase
    end
  end

  // Read decode: data and response for the address on the AR channel
  always_comb begin
    rd_region_c = decode_addr(s_axi.araddr[DEC_WIDTH-1:0]);
    rd_res_c    = result[s_axi.araddr[4:2]];
    rd_data_c   = '0;
    rd_resp_c   = RESP_OKAY;
    case (rd_region_c)
      REGION_CTRL: begin
        rd_data_c[CTRL_SOFT_RST_BIT] = soft_rst;
        rd_data_c[CTRL_IRQ_EN_BIT]   = irq_en;
      end
      REGION_STATUS: begin
        rd_data_c[STATUS_BUSY_BIT] = busy;
        rd_data_c[STATUS_DONE_BIT] = done_sticky;
      end
      REGION_CONFIG: rd_data_c = AXI_DATA_WIDTH'(cfg);
      REGION_WEIGHT, REGION_INPUT: rd_data_c = '0;
      REGION_RESULT: rd_data_c = {{(AXI_DATA_WIDTH-DATA_WIDTH){rd_res_c[DATA_WIDTH-1]}}, rd_res_c};
      default: rd_resp_c = RESP_SLVERR;
    endcase
  end

  // Bus state, registers and core-side outputs
  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_full       <= 1'b0;
      w_full        <= 1'b0;
      aw_addr       <= '0;
      w_data        <= '0;
      s_axi.awready <= 1'b0;
      s_axi.wready  <= 1'b0;
      s_axi.arready <= 1'b0;
      s_axi.bvalid  <= 1'b0;
      s_axi.bresp   <= RESP_OKAY;
      s_axi.rvalid  <= 1'b0;
      s_axi.rresp   <= RESP_OKAY;
      s_axi.rdata   <= '0;
      soft_rst      <= 1'b0;
      irq_en        <= 1'b0;
      start         <= 1'b0;
      cfg           <= CONFIG_RESET;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_data      <= '0;
      done_sticky   <= 1'b0;
      interrupt     <= 1'b0;
      for (int i = 0; i < int'(MATRIX_SIZE); i++) result[i] <= '0;
    end else begin
      aw_full       <= aw_full_n_c;
      w_full        <= w_full_n_c;
      s_axi.awready <= ~aw_full_n_c & ~bvalid_n_c;
      s_axi.wready  <= ~w_full_n_c & ~bvalid_n_c;
      s_axi.arready <= ~rvalid_n_c;
      s_axi.bvalid  <= bvalid_n_c;
      s_axi.rvalid  <= rvalid_n_c;
      if (aw_hs_c) aw_addr <= s_axi.awaddr[DEC_WIDTH-1:0];
      if (w_hs_c)  w_data  <= s_axi.wdata[DATA_WIDTH-1:0];
      if (wr_go_c) s_axi.bresp <= wr_resp_c;
      if (ar_hs_c) begin
        s_axi.rdata <= rd_data_c;
        s_axi.rresp <= rd_resp_c;
      end

      if (ctrl_wr_c) begin
        soft_rst <= w_data[CTRL_SOFT_RST_BIT];
        irq_en   <= w_data[CTRL_IRQ_EN_BIT];
      end
      if (cfg_wr_c) cfg <= w_data;

      start  <= start_go_c;
      mem_we <= mem_wr_c;
      if (mem_wr_c) begin
        mem_addr <= mem_addr_c;
        mem_data <= w_data;
      end

      // Start outranks a coincident done; soft reset holds the flag clear
      if (start_go_c || soft_rst)
        done_sticky <= 1'b0;
      else if (done)
        done_sticky <= 1'b1;
      interrupt <= done_sticky & irq_en;

      if (soft_rst) begin
        for (int i = 0; i < int'(MATRIX_SIZE); i++) result[i] <= '0;
      end else if (res_we) begin
        result[res_idx] <= res_data;
      end
    end
  end

endmodule

// File: tb/tb_npu_axil_slave.sv
// Scoreboard bench for npu_axil_slave: tasks push expected B/R/mem responses
// into queues; a negedge monitor pops and compares on each DUT handshake.
module tb_npu_axil_slave;
  import npu_pkg::*;

  logic aclk;
  logic areset;
  logic soft_rst, start, mem_we, interrupt;
  logic [15:0] cfg;
  logic [6:0]  mem_addr;
  logic [15:0] mem_data;
  logic busy, done, res_we;
  logic [2:0]  res_idx;
  logic [15:0] res_data;

  npu_axil_slave_if s_axi ();

  npu_axil_slave dut (
    .aclk      (aclk),
    .areset    (areset),
    .s_axi     (s_axi),
    .soft_rst  (soft_rst),
    .start     (start),
    .cfg       (cfg),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .busy      (busy),
    .done      (done),
    .res_we    (res_we),
    .res_idx   (res_idx),
    .res_data  (res_data),
    .interrupt (interrupt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int b_seen = 0;
  int r_seen = 0;
  int mem_cnt = 0;
  int start_cnt = 0;

  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];
  logic [22:0] exp_mem [$];
  logic [1:0]  mon_b;
  logic [33:0] mon_r;
  logic [22:0] mon_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out, expected event never seen", name);
  endtask

  // Monitor: compare each DUT-presented response against the scoreboard
  always @(negedge aclk) begin
    if (!areset) begin
      if (s_axi.bvalid && s_axi.bready) begin
        b_seen++;
        if (exp_b.size() == 0) begin
          timeout_fail("b_unexpected");
        end else begin
          mon_b = exp_b.pop_front();
          chk("bresp", 64'(s_axi.bresp), 64'(mon_b));
        end
      end
      if (s_axi.rvalid && s_axi.rready) begin
        r_seen++;
        if (exp_r.size() == 0) begin
          timeout_fail("r_unexpected");
        end else begin
          mon_r = exp_r.pop_front();
          chk("rresp_rdata", 64'({s_axi.rresp, s_axi.rdata}), 64'(mon_r));
        end
      end
      if (mem_we) begin
        mem_cnt++;
        chk("mem_we_with_bvalid", 64'(s_axi.bvalid), 64'(1));
        if (exp_mem.size() == 0) begin
          timeout_fail("mem_we_unexpected");
        end else begin
          mon_m = exp_mem.pop_front();
          chk("mem_addr_data", 64'({mem_addr, mem_data}), 64'(mon_m));
        end
      end
      if (start) start_cnt++;
    end
  end

  task automatic aw_chan(input logic [31:0] a);
    int n;
    n = 0;
    s_axi.awaddr  = a;
    s_axi.awvalid = 1'b1;
    @(negedge aclk);
    while (!s_axi.awready && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) timeout_fail("aw_accept");
    @(posedge aclk);
    #1 s_axi.awvalid = 1'b0;
  endtask

  task automatic w_chan(input logic [31:0] d);
    int n;
    n = 0;
    s_axi.wdata  = d;
    s_axi.wvalid = 1'b1;
    @(negedge aclk);
    while (!s_axi.wready && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) timeout_fail("w_accept");
    @(posedge aclk);
    #1 s_axi.wvalid = 1'b0;
  endtask

  task automatic ar_chan(input logic [31:0] a);
    int n;
    n = 0;
    s_axi.araddr  = a;
    s_axi.arvalid = 1'b1;
    @(negedge aclk);
    while (!s_axi.arready && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) timeout_fail("ar_accept");
    @(posedge aclk);
    #1 s_axi.arvalid = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input int aw_lag, input int w_lag, input logic [1:0] resp);
    int target;
    int n;
    target = b_seen + 1;
    exp_b.push_back(resp);
    fork
      begin repeat (aw_lag) @(posedge aclk); if (aw_lag > 0) #1; aw_chan(a); end
      begin repeat (w_lag) @(posedge aclk); if (w_lag > 0) #1; w_chan(d); end
    join
    n = 0;
    while (b_seen < target && n < 100) begin @(negedge aclk); n++; end
    if (b_seen < target) timeout_fail("b_wait");
    @(posedge aclk);
    #1;
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [1:0] resp, input logic [31:0] d);
    int target;
    int n;
    target = r_seen + 1;
    exp_r.push_back({resp, d});
    ar_chan(a);
    n = 0;
    while (r_seen < target && n < 100) begin @(negedge aclk); n++; end
    if (r_seen < target) timeout_fail("r_wait");
    @(posedge aclk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int s0, b0, m0;

  initial begin
    areset = 1'b1;
    s_axi.awaddr = '0; s_axi.awvalid = 1'b0;
    s_axi.wdata = '0;  s_axi.wvalid = 1'b0;
    s_axi.bready = 1'b1;
    s_axi.araddr = '0; s_axi.arvalid = 1'b0;
    s_axi.rready = 1'b1;
    busy = 1'b0; done = 1'b0; res_we = 1'b0; res_idx = '0; res_data = '0;

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_awready", 64'(s_axi.awready), 64'(0));
    chk("rst_wready", 64'(s_axi.wready), 64'(0));
    chk("rst_arready", 64'(s_axi.arready), 64'(0));
    chk("rst_cfg", 64'(cfg), 64'(16'h0008));
    @(posedge aclk);
    #1 areset = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    chk("post_rst_ready", 64'({s_axi.awready, s_axi.wready, s_axi.arready}), 64'(3'b111));
    chk("post_rst_valids", 64'({s_axi.bvalid, s_axi.rvalid}), 64'(0));
    chk("post_rst_outs", 64'({soft_rst, start, mem_we, interrupt}), 64'(0));
    @(posedge aclk);
    #1;

    // CONFIG write/read
    axi_write(32'h008, 32'h0000_0108, 0, 0, RESP_OKAY);
    axi_read(32'h008, RESP_OKAY, 32'h0000_0108);
    chk("cfg_out", 64'(cfg), 64'(16'h0108));

    // AW three cycles ahead of W, weight write
    b0 = b_seen; m0 = mem_cnt;
    exp_mem.push_back({7'd1, 16'h0100});
    axi_write(32'h104, 32'h0000_0100, 0, 3, RESP_OKAY);
    cycles(3);
    chk("weight_mem_we_count", 64'(mem_cnt - m0), 64'(1));
    chk("weight_b_count", 64'(b_seen - b0), 64'(1));

    // Input write (upper data ignored) and W ahead of AW
    exp_mem.push_back({7'd71, 16'h1234});
    axi_write(32'h21C, 32'hDEAD_1234, 0, 0, RESP_OKAY);
    exp_mem.push_back({7'd63, 16'hABCD});
    axi_write(32'h1FC, 32'h0000_ABCD, 2, 0, RESP_OKAY);

    // irq_en, start pulse, done -> STATUS and interrupt
    axi_write(32'h000, 32'h4, 0, 0, RESP_OKAY);
    axi_read(32'h000, RESP_OKAY, 32'h4);
    s0 = start_cnt;
    axi_write(32'h000, 32'h6, 0, 0, RESP_OKAY);
    cycles(2);
    chk("start_pulse_count", 64'(start_cnt - s0), 64'(1));
    axi_read(32'h000, RESP_OKAY, 32'h4);
    axi_read(32'h004, RESP_OKAY, 32'h0);
    @(posedge aclk); #1 done = 1'b1;
    @(posedge aclk); #1 done = 1'b0;
    cycles(2);
    axi_read(32'h004, RESP_OKAY, 32'h2);
    chk("interrupt_set", 64'(interrupt), 64'(1));

    // soft_rst together with start: no start, done_sticky cleared
    s0 = start_cnt;
    axi_write(32'h000, 32'h3, 0, 0, RESP_OKAY);
    cycles(2);
    chk("start_ignored_soft", 64'(start_cnt - s0), 64'(0));
    chk("soft_rst_level", 64'(soft_rst), 64'(1));
    axi_read(32'h004, RESP_OKAY, 32'h0);
    axi_read(32'h000, RESP_OKAY, 32'h1);
    chk("interrupt_clear", 64'(interrupt), 64'(0));
    axi_write(32'h000, 32'h0, 0, 0, RESP_OKAY);

    // Busy core: start ignored, operand writes rejected
    busy = 1'b1;
    s0 = start_cnt;
    axi_write(32'h000, 32'h2, 0, 0, RESP_OKAY);
    cycles(2);
    chk("start_ignored_busy", 64'(start_cnt - s0), 64'(0));
    axi_read(32'h004, RESP_OKAY, 32'h1);
    axi_write(32'h200, 32'h5555, 0, 0, RESP_SLVERR);
    axi_write(32'h104, 32'h0001, 0, 0, RESP_SLVERR);
    axi_read(32'h400, RESP_SLVERR, 32'h0);
    busy = 1'b0;

    // RO / unmapped writes, WO and unmapped reads
    axi_write(32'h004, 32'h3, 0, 0, RESP_SLVERR);
    axi_write(32'h300, 32'h1, 0, 0, RESP_SLVERR);
    axi_write(32'h00C, 32'h1, 0, 0, RESP_SLVERR);
    axi_write(32'h400, 32'h1, 0, 0, RESP_SLVERR);
    axi_read(32'h008, RESP_OKAY, 32'h0000_0108);
    axi_read(32'h104, RESP_OKAY, 32'h0);
    axi_read(32'h200, RESP_OKAY, 32'h0);
    axi_read(32'h220, RESP_SLVERR, 32'h0);

    // Results: sign extension and soft_rst clear
    @(posedge aclk); #1 res_we = 1'b1; res_idx = 3'd7; res_data = 16'hFF00;
    @(posedge aclk); #1 res_idx = 3'd0; res_data = 16'h1234;
    @(posedge aclk); #1 res_we = 1'b0;
    axi_read(32'h31C, RESP_OKAY, 32'hFFFF_FF00);
    axi_read(32'h300, RESP_OKAY, 32'h0000_1234);
    axi_read(32'h304, RESP_OKAY, 32'h0);
    axi_write(32'h000, 32'h1, 0, 0, RESP_OKAY);
    cycles(2);
    axi_read(32'h31C, RESP_OKAY, 32'h0);
    axi_read(32'h300, RESP_OKAY, 32'h0);
    axi_write(32'h000, 32'h0, 0, 0, RESP_OKAY);
    chk("mem_we_total", 64'(mem_cnt), 64'(3));

    // Reset discards a pending read response
    s_axi.rready = 1'b0;
    ar_chan(32'h008);
    chk("rvalid_pending", 64'(s_axi.rvalid), 64'(1));
    areset = 1'b1;
    @(posedge aclk); #1;
    chk("rvalid_after_reset", 64'(s_axi.rvalid), 64'(0));
    chk("arready_in_reset", 64'(s_axi.arready), 64'(0));
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    s_axi.rready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    chk("cfg_after_reset", 64'(cfg), 64'(16'h0008));
    chk("arready_after_reset", 64'(s_axi.arready), 64'(1));
    @(posedge aclk); #1;
    axi_read(32'h008, RESP_OKAY, 32'h0000_0008);

    cycles(3);
    chk("b_queue_drained", 64'(exp_b.size()), 64'(0));
    chk("r_queue_drained", 64'(exp_r.size()), 64'(0));
    chk("mem_queue_drained", 64'(exp_mem.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/npu_axil_slave.md
NPU_AXIL_SLAVE -- requirements
Module: npu_axil_slave

Interface
REQ-001 AXI_ADDR_WIDTH, 32, AXI address width; only bits [11:0] are decoded.
REQ-002 DATA_WIDTH, 16, operand/result width in Q8.8.
REQ-003 MATRIX_SIZE, 8, vector length; weight count is MATRIX_SIZE*MATRIX_SIZE.
REQ-004 aclk  in  1  single clock; all logic on rising edge.
REQ-005 areset  in  1  synchronous, active-high reset.
REQ-006 s_axi_awaddr  in  AXI_ADDR_WIDTH  write address.
REQ-007 s_axi_awvalid  in  1  write address valid.
REQ-008 s_axi_awready  out  1  write address ready.
REQ-009 s_axi_wdata  in  32  write data.
REQ-010 s_axi_wvalid  in  1  write data valid.
REQ-011 s_axi_wready  out  1  write data ready.
REQ-012 s_axi_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
REQ-013 s_axi_bvalid  out  1  write response valid.
REQ-014 s_axi_bready  in  1  write response ready.
REQ-015 s_axi_araddr  in  AXI_ADDR_WIDTH  read address.
REQ-016 s_axi_arvalid  in  1  read address valid.
REQ-017 s_axi_arready  out  1  read address ready.
REQ-018 s_axi_rdata  out  32  read data.
REQ-019 s_axi_rresp  out  2  read response, same encoding as bresp.
REQ-020 s_axi_rvalid  out  1  read data valid.
REQ-021 s_axi_rready  in  1  read data ready.
REQ-022 soft_rst  out  1  level, equals CTRL[0].
REQ-023 start  out  1  one-cycle compute start pulse.
REQ-024 cfg  out  16  equals CONFIG[15:0]: [7:0] size, [9:8] activation select.
REQ-025 mem_we  out  1  one-cycle operand write strobe.
REQ-026 mem_addr  out  7  0..63 weight index (row*8+col); 64..71 input index.
REQ-027 mem_data  out  DATA_WIDTH  equals wdata[15:0].
REQ-028 busy  in  1  core is computing.
REQ-029 done  in  1  one-cycle completion pulse from the core.
REQ-030 res_we  in  1  result write strobe.
REQ-031 res_idx  in  3  result index.
REQ-032 res_data  in  DATA_WIDTH  result value.
REQ-033 interrupt  out  1  registered: done_sticky & CTRL[2].

Function
REQ-034 AW and W channels are captured independently.
- awready=1 while the AW holding register is empty and bvalid=0; wready=1 under the same rule for W.
- On the edge after both are held: the block performs the write, drives bvalid=1 with bresp, and holds until bready; both buffers free on the B handshake.
REQ-035 Reads:
- arready=1 while rvalid=0.
- On the edge after the AR handshake: registered rdata/rresp, rvalid=1, held until rready; one read outstanding.
REQ-036 Register map:
- 0x000 CTRL RW: [0] soft_rst, [1] start (write-1 pulse, reads 0), [2] irq_en.
- 0x004 STATUS RO: [0] busy, [1] done_sticky.
- 0x008 CONFIG RW [15:0].
- 0x100-0x1FC weights WO: mem_addr=(a-0x100)>>2.
- 0x200-0x21C inputs WO: mem_addr=64+((a-0x200)>>2).
- 0x300-0x31C results RO: 16-bit value sign-extended to 32.
REQ-037 Error and read-back rules:
- Unmapped address, write to an RO region, or write to 0x100-0x21C while busy=1: SLVERR, no side effect.
- Reads of WO regions: 0 with OKAY.
- Unmapped reads: 0 with SLVERR.
REQ-038 mem_we pulses in the same cycle as bvalid rises for an accepted operand write.
REQ-039 start pulses in the cycle bvalid rises, only when wdata[1]=1, busy=0 and wdata[0]=0; otherwise the start bit is ignored with OKAY.
REQ-040 done sets done_sticky; start clears it; if start and done coincide, start wins (done_sticky=0).
REQ-041 res_we writes result[res_idx]; soft_rst=1 clears all results and done_sticky every cycle it is held.

Reset
REQ-042 Reset values:
- All outputs and registers 0, except CONFIG=0x0008.
- awready/wready/arready=0 during reset, 1 on the first cycle after.
- An in-flight transaction is discarded.

Structure
REQ-043 Package npu_pkg holds region offsets, CTRL/STATUS bit positions, RESP_OKAY/RESP_SLVERR and an address-decode function; no sub-module is needed.

Verification
REQ-044 Write 0x008=0x0108 -> bresp OKAY; read 0x008 returns 0x00000108; cfg=0x0108.
REQ-045 AW issued 3 cycles before W to 0x104 data 0x0100 -> one mem_we, mem_addr=1, mem_data=0x0100, exactly one bvalid.
REQ-046 Write 0x000=0x2 with busy=0 -> start pulses 1 cycle; done pulse -> STATUS reads 0x2; with irq_en=1, interrupt=1.
REQ-047 busy=1, write 0x200 -> SLVERR, no mem_we; read 0x400 -> rdata 0, SLVERR.
REQ-048 res_we idx 7 data 0xFF00 -> read 0x31C returns 0xFFFFFF00; areset asserted while rvalid=1 with rready=0 -> rvalid=0 the next cycle.
